// File: rtl/adder_stim_checker.sv
// adder_stim_checker: pseudo-random stimulus generator and response checker
// wrapped around a registered W-bit adder with LAT pipeline stages.
//
// Control handshake: `start` is a one-cycle request with no ready signal. It
// is accepted only on a cycle where `busy` is low (IDLE or DONE). While
// `busy` is high, `start` is ignored. `done` is a level that stays high from
// the end of a run until the next accepted `start`.
module adder_stim_checker #(
    parameter int W   = 32,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [31:0]  seed,
    input  logic [15:0]  num_vec,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         c_in,
    input  logic         c_out,
    input  logic [W-1:0] sum,
    output logic         busy,
    output logic         done,
    output logic [15:0]  pass_cnt,
    output logic [15:0]  fail_cnt,
    output logic         fail_seen,
    output logic [15:0]  first_fail_idx,
    output logic [1:0]   dbg_state
);

    localparam logic [31:0] POLY = 32'h80200003;
    localparam int          DW   = $clog2(LAT + 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [31:0]     lfsr_a;
    logic [31:0]     lfsr_b;
    logic [15:0]     num_vec_q;
    logic [15:0]     issue_idx;
    logic [DW-1:0]   drain_cnt;

    // Expected-result pipe; index LAT is the head that meets the adder output.
    logic [W:0]      pipe_exp [LAT+1];
    logic [15:0]     pipe_idx [LAT+1];
    logic [LAT:0]    pipe_vld;

    logic            start_ok;
    logic            issue_fire;
    logic            drain_last;
    logic [31:0]     seed_a;
    logic [31:0]     seed_b;
    logic [W-1:0]    ref_a;
    logic [W-1:0]    ref_b;
    logic            ref_c;
    logic [W:0]      ref_sum;
    logic            head_vld;
    logic            head_bad;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    // Control decodes and the reference result for the vector being issued.
    always_comb begin
        start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
        issue_fire = (state == S_ISSUE) && (issue_idx != num_vec_q);
        drain_last = (state == S_DRAIN) && (drain_cnt == DW'(LAT));
        seed_a     = (seed == 32'h0) ? 32'h1 : seed;
        seed_b     = (~seed == 32'h0) ? 32'h1 : ~seed;
        ref_a      = lfsr_a[W-1:0];
        ref_b      = lfsr_b[W-1:0];
        ref_c      = lfsr_a[31] ^ lfsr_b[31];
        ref_sum    = {1'b0, ref_a} + {1'b0, ref_b} + {{W{1'b0}}, ref_c};
        head_vld   = pipe_vld[LAT];
        head_bad   = ({c_out, sum} != pipe_exp[LAT]);
        busy       = (state == S_ISSUE) || (state == S_DRAIN);
        done       = (state == S_DONE);
        dbg_state  = state;
    end

    // Next-state logic; a zero-length run jumps straight to DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = (num_vec != 16'h0) ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                if (issue_idx == num_vec_q) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_last) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Operand generation: seed the LFSRs on start, issue one vector per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_a    <= 32'h1;
            lfsr_b    <= 32'h1;
            num_vec_q <= 16'h0;
            issue_idx <= 16'h0;
            drain_cnt <= '0;
            a         <= '0;
            b         <= '0;
            c_in      <= 1'b0;
        end else begin
            if (start_ok && (num_vec != 16'h0)) begin
                lfsr_a    <= seed_a;
                lfsr_b    <= seed_b;
                num_vec_q <= num_vec;
                issue_idx <= 16'h0;
            end else if (issue_fire) begin
                a         <= ref_a;
                b         <= ref_b;
                c_in      <= ref_c;
                lfsr_a    <= lfsr_step(lfsr_a);
                lfsr_b    <= lfsr_step(lfsr_b);
                issue_idx <= issue_idx + 16'h1;
            end
            if (state == S_DRAIN) drain_cnt <= drain_cnt + DW'(1);
            else                  drain_cnt <= '0;
        end
    end

    // Expected-result pipe shifting alongside the adder's own register stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i <= LAT; i++) begin
                pipe_exp[i] <= '0;
                pipe_idx[i] <= '0;
            end
        end else begin
            for (int i = LAT; i >= 1; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_exp[i] <= pipe_exp[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            pipe_vld[0] <= issue_fire;
            pipe_exp[0] <= ref_sum;
            pipe_idx[0] <= issue_idx;
        end
    end

    // Result counters and first-mismatch capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt       <= 16'h0;
            fail_cnt       <= 16'h0;
            fail_seen      <= 1'b0;
            first_fail_idx <= 16'h0;
        end else if (start_ok) begin
            pass_cnt <= 16'h0;
            fail_cnt <= 16'h0;
            if (num_vec != 16'h0) begin
                fail_seen      <= 1'b0;
                first_fail_idx <= 16'h0;
            end
        end else if (head_vld) begin
            if (!head_bad) begin
                pass_cnt <= pass_cnt + 16'h1;
            end else begin
                fail_cnt <= fail_cnt + 16'h1;
                if (!fail_seen) begin
                    fail_seen      <= 1'b1;
                    first_fail_idx <= pipe_idx[LAT];
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_stim_checker.sv
// tb_adder_stim_checker: directed runs of the stimulus/checker against
// behavioural adders (W=32/LAT=1 and W=8/LAT=2), with optional stuck-at faults.
module tb_adder_stim_checker;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT 1: W=32, LAT=1 ----------------
    logic        start, c_in, c_out, busy, done, fail_seen;
    logic [31:0] seed, a, b, sum;
    logic [15:0] num_vec, pass_cnt, fail_cnt, first_fail_idx;
    logic [1:0]  dbg_state;
    logic        stuck_s0;
    logic [32:0] add1_r;

    adder_stim_checker #(.W(32), .LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_vec(num_vec),
        .a(a), .b(b), .c_in(c_in), .c_out(c_out), .sum(sum),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .fail_seen(fail_seen), .first_fail_idx(first_fail_idx), .dbg_state(dbg_state)
    );

    // One-stage adder; optional sum[0] stuck-at-0.
    always @(posedge clk) add1_r <= {1'b0, a} + {1'b0, b} + {32'h0, c_in};
    assign sum   = {add1_r[31:1], add1_r[0] & ~stuck_s0};
    assign c_out = add1_r[32];

    // ---------------- DUT 2: W=8, LAT=2 ----------------
    logic        start2, c_in2, c_out2, busy2, done2, fail_seen2;
    logic [31:0] seed2;
    logic [7:0]  a2, b2, sum2;
    logic [15:0] num_vec2, pass_cnt2, fail_cnt2, first_fail_idx2;
    logic [1:0]  dbg_state2;
    logic        stuck_co;
    logic [8:0]  add2_r0, add2_r1;

    adder_stim_checker #(.W(8), .LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed2), .num_vec(num_vec2),
        .a(a2), .b(b2), .c_in(c_in2), .c_out(c_out2), .sum(sum2),
        .busy(busy2), .done(done2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2),
        .fail_seen(fail_seen2), .first_fail_idx(first_fail_idx2), .dbg_state(dbg_state2)
    );

    // Two-stage adder; optional c_out stuck-at-0.
    always @(posedge clk) begin
        add2_r0 <= {1'b0, a2} + {1'b0, b2} + {8'h0, c_in2};
        add2_r1 <= add2_r0;
    end
    assign sum2   = add2_r1[7:0];
    assign c_out2 = add2_r1[8] & ~stuck_co;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [64:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference LFSR, written from the step rule.
    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h80200003;
        return r;
    endfunction

    function automatic logic [31:0] fix_seed(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    // ---------------- driver tasks ----------------
    // Returns #1 after the edge that samples start.
    task automatic start_run(input bit sel, input logic [31:0] sd, input logic [15:0] nv);
        @(negedge clk);
        if (!sel) begin seed = sd;  num_vec = nv;  start = 1'b1;  end
        else      begin seed2 = sd; num_vec2 = nv; start2 = 1'b1; end
        @(posedge clk);
        #1;
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // Counts edges after the start edge until done is seen (bounded).
    task automatic wait_done(input bit sel, input int n0, output int n);
        n = n0;
        while (!(sel ? done2 : done) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("done_seen", {64'h0, (sel ? done2 : done)}, 65'h1);
    endtask

    // ---------------- stimulus ----------------
    int          n;
    int          exp_fail;
    int          exp_first;
    logic [31:0] ma, mb;
    logic [31:0] ta, tb;
    logic        tc;
    logic [8:0]  s9;

    initial begin
        rst_n = 1'b0;
        start = 1'b0; seed = '0; num_vec = '0; stuck_s0 = 1'b0;
        start2 = 1'b0; seed2 = '0; num_vec2 = '0; stuck_co = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_a", {33'h0, a}, 65'h0);
        check_eq("rst_b", {33'h0, b}, 65'h0);
        check_eq("rst_cin_busy_done", {62'h0, c_in, busy, done}, 65'h0);
        check_eq("rst_cnts", {33'h0, pass_cnt, fail_cnt}, 65'h0);
        check_eq("rst_fail_info", {48'h0, fail_seen, first_fail_idx}, 65'h0);
        check_eq("rst_state", {63'h0, dbg_state}, 65'h0);
        check_eq("rst_dut2", {44'h0, a2, b2, c_in2, busy2, done2, fail_seen2, pass_cnt2[0], fail_cnt2[0]}, 65'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Golden vector: seed=1, one vector
        start_run(0, 32'h1, 16'd1);
        @(posedge clk); #1;
        check_eq("gold_a", {33'h0, a}, 65'h1);
        check_eq("gold_b", {33'h0, b}, {33'h0, 32'hFFFFFFFE});
        check_eq("gold_cin", {64'h0, c_in}, 65'h1);
        wait_done(0, 1, n);
        check_eq("gold_done_cycle", n, 4);
        check_eq("gold_pass", {49'h0, pass_cnt}, 65'd1);
        check_eq("gold_fail", {48'h0, fail_seen, fail_cnt}, 65'd0);

        // seed=0 behaves like seed=1 for lfsr_a; lfsr_b gets ~0
        start_run(0, 32'h0, 16'd1);
        @(posedge clk); #1;
        check_eq("seed0_a", {33'h0, a}, 65'h1);
        check_eq("seed0_b_cin", {32'h0, c_in, b}, {32'h0, 1'b1, 32'hFFFFFFFF});
        wait_done(0, 1, n);
        check_eq("seed0_pass", {49'h0, pass_cnt}, 65'd1);

        // Full clean run
        start_run(0, 32'hACE12345, 16'd1000);
        wait_done(0, 0, n);
        check_eq("full_done_cycle", n, 1003);
        check_eq("full_pass", {49'h0, pass_cnt}, 65'd1000);
        check_eq("full_fail", {49'h0, fail_cnt}, 65'd0);

        // Fault injection: sum[0] stuck-at-0, operand stream also checked
        exp_fail = 0; exp_first = -1;
        ma = fix_seed(32'h1); mb = fix_seed(~32'h1);
        for (int i = 0; i < 16; i++) begin
            tc = ma[31] ^ mb[31];
            exp_q.push_back({tc, mb, ma});
            if (ma[0] ^ mb[0] ^ tc) begin
                exp_fail++;
                if (exp_first < 0) exp_first = i;
            end
            ma = model_step(ma); mb = model_step(mb);
        end
        stuck_s0 = 1'b1;
        start_run(0, 32'h1, 16'd16);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            check_eq("fault_operands", {c_in, b, a}, exp_q.pop_front());
        end
        wait_done(0, 16, n);
        stuck_s0 = 1'b0;
        check_eq("fault_fail_cnt", {49'h0, fail_cnt}, exp_fail);
        check_eq("fault_first_idx", {49'h0, first_fail_idx}, exp_first);
        check_eq("fault_seen", {64'h0, fail_seen}, 65'h1);
        check_eq("fault_total", {48'h0, pass_cnt + fail_cnt}, 65'd16);

        // start pulsed mid-ISSUE is ignored
        start_run(0, 32'h00001234, 16'd20);
        repeat (5) begin @(posedge clk); #1; end
        @(negedge clk);
        seed = 32'd99; num_vec = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("midstart_busy", {64'h0, busy}, 65'h1);
        wait_done(0, 6, n);
        check_eq("midstart_done_cycle", n, 23);
        check_eq("midstart_pass", {33'h0, pass_cnt, fail_cnt}, {33'h0, 16'd20, 16'd0});

        // num_vec=0 from DONE: DONE right after the start edge, counts cleared
        start_run(0, 32'h5, 16'd0);
        check_eq("nv0_done_busy", {63'h0, done, busy}, 65'b10);
        check_eq("nv0_cnts", {33'h0, pass_cnt, fail_cnt}, 65'h0);

        // Asynchronous reset during ISSUE
        start_run(0, 32'hBEEF0001, 16'd100);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_ops", {c_in, b, a}, 65'h0);
        check_eq("midrst_status", {62'h0, busy, done, fail_seen}, 65'h0);
        check_eq("midrst_cnts", {33'h0, pass_cnt, fail_cnt}, 65'h0);
        check_eq("midrst_state", {63'h0, dbg_state}, 65'h0);
        @(negedge clk);
        rst_n = 1'b1;
        start_run(0, 32'hBEEF0001, 16'd100);
        wait_done(0, 0, n);
        check_eq("postrst_pass", {33'h0, pass_cnt, fail_cnt}, {33'h0, 16'd100, 16'd0});

        // W=8, LAT=2 clean run
        start_run(1, 32'h5A5A0001, 16'd256);
        wait_done(1, 0, n);
        check_eq("w8_done_cycle", n, 260);
        check_eq("w8_pass", {33'h0, pass_cnt2, fail_cnt2}, {33'h0, 16'd256, 16'd0});

        // W=8: carry-out (bit 8) stuck-at-0 must be caught
        exp_fail = 0; exp_first = -1;
        ma = fix_seed(32'h7); mb = fix_seed(~32'h7);
        for (int i = 0; i < 32; i++) begin
            ta = ma; tb = mb;
            tc = ma[31] ^ mb[31];
            s9 = {1'b0, ta[7:0]} + {1'b0, tb[7:0]} + {8'h0, tc};
            if (s9[8]) begin
                exp_fail++;
                if (exp_first < 0) exp_first = i;
            end
            ma = model_step(ma); mb = model_step(mb);
        end
        stuck_co = 1'b1;
        start_run(1, 32'h7, 16'd32);
        wait_done(1, 0, n);
        stuck_co = 1'b0;
        check_eq("w8_cout_fail_cnt", {49'h0, fail_cnt2}, exp_fail);
        check_eq("w8_cout_first_idx", {49'h0, first_fail_idx2}, exp_first);
        check_eq("w8_cout_total", {48'h0, pass_cnt2 + fail_cnt2}, 65'd32);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
